// File: rtl/repeat_seq_counter_pkg.sv
// Shared encodings for the repeat-sequence counter: FSM states and direction values.
package repeat_seq_counter_pkg;

   // Two-state controller: RUN advances the sequence, HALT holds the terminal value.
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   // Direction select values for dir_i.
   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/repeat_seq_counter.sv
// Repeat-sequence counter: emits each value v in 1..MAX_VAL exactly v times,
// ascending or descending, with enable, wrap-or-halt end mode and restart.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset (count=1, rep=1, RUN)
//   en_i        advance enable; low holds all state
//   restart_i   reload START (1 ascending, MAX_VAL descending), clears halt
//   dir_i       0 ascending, 1 descending; sampled at value boundaries
//   wrap_i      1 restart after the terminal value, 0 halt on it
//   count_o     current sequence value (registered)
//   rep_o       repetition index of count_o, 1..count_o (registered)
//   last_rep_o  combinational: rep_o == count_o while not halted
//   seq_done_o  registered one-cycle pulse at the end of a sequence
//   halted_o    registered: holding the terminal value
module repeat_seq_counter #(
   parameter int unsigned WIDTH   = 6,
   parameter int unsigned MAX_VAL = 7
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             restart_i,
   input  logic             dir_i,
   input  logic             wrap_i,
   output logic [WIDTH-1:0] count_o,
   output logic [WIDTH-1:0] rep_o,
   output logic             last_rep_o,
   output logic             seq_done_o,
   output logic             halted_o
);
   import repeat_seq_counter_pkg::*;

   // MAX_VAL must be representable and non-zero.
   if ((MAX_VAL < 1) || (MAX_VAL > ((2 ** WIDTH) - 1))) begin : g_bad_max_val
      $error("repeat_seq_counter: MAX_VAL out of range 1..2^WIDTH-1");
   end

   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] rep_q, rep_d;
   logic             seq_done_q, seq_done_d;
   logic [WIDTH-1:0] start_c;
   logic [WIDTH-1:0] term_c;

   // Sequence endpoints follow the currently presented direction.
   assign start_c = (dir_i == DIR_DN) ? MAX_W : ONE_W;
   assign term_c  = (dir_i == DIR_UP) ? MAX_W : ONE_W;

   // State register; reset always loads 1 regardless of direction.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_RUN;
         count_q    <= ONE_W;
         rep_q      <= ONE_W;
         seq_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         rep_q      <= rep_d;
         seq_done_q <= seq_done_d;
      end
   end

   // Next-state logic; dir/wrap only matter once the last repetition is reached.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      rep_d      = rep_q;
      seq_done_d = 1'b0;

      if (restart_i) begin
         state_d = ST_RUN;
         count_d = start_c;
         rep_d   = ONE_W;
      end else if (en_i && (state_q == ST_RUN)) begin
         if (rep_q < count_q) begin
            rep_d = rep_q + ONE_W;
         end else if (count_q == term_c) begin
            seq_done_d = 1'b1;
            if (wrap_i) begin
               count_d = start_c;
               rep_d   = ONE_W;
            end else begin
               state_d = ST_HALT;
            end
         end else begin
            count_d = (dir_i == DIR_DN) ? (count_q - ONE_W) : (count_q + ONE_W);
            rep_d   = ONE_W;
         end
      end
   end

   assign count_o    = count_q;
   assign rep_o      = rep_q;
   assign seq_done_o = seq_done_q;
   assign halted_o   = (state_q == ST_HALT);
   assign last_rep_o = (rep_q == count_q) && (state_q == ST_RUN);

endmodule

// File: tb/tb_repeat_seq_counter.sv
// Self-checking bench: two instances (MAX_VAL=3 and the MAX_VAL=1 corner)
// compared each cycle against a behavioural model, plus directed sequence tables.
module tb_repeat_seq_counter;

   typedef struct {
      int cnt;
      int rep;
      bit halt;
      bit done;
   } mstate_t;

   logic clk;
   logic rst, en, restart, dir, wrap;

   logic [5:0] count3, rep3;
   logic       last3, done3, halt3;
   logic [0:0] count1, rep1;
   logic       last1, done1, halt1;

   int n_checks = 0;
   int n_errors = 0;

   mstate_t m3, m1;
   int up_cnt[$], up_rep[$], dn_cnt[$], dn_rep[$];

   repeat_seq_counter #(.WIDTH(6), .MAX_VAL(3)) u_dut3 (
      .clk_i(clk), .rst_i(rst), .en_i(en), .restart_i(restart), .dir_i(dir), .wrap_i(wrap),
      .count_o(count3), .rep_o(rep3), .last_rep_o(last3), .seq_done_o(done3), .halted_o(halt3)
   );

   repeat_seq_counter #(.WIDTH(1), .MAX_VAL(1)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .en_i(en), .restart_i(restart), .dir_i(dir), .wrap_i(wrap),
      .count_o(count1), .rep_o(rep1), .last_rep_o(last1), .seq_done_o(done1), .halted_o(halt1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: one enabled cycle consumes one emission of the sequence.
   function automatic mstate_t model_step(input mstate_t s, input int maxv);
      mstate_t n = s;
      int first = dir ? maxv : 1;
      int last  = dir ? 1 : maxv;
      n.done = 1'b0;
      if (rst) begin
         n.cnt = 1; n.rep = 1; n.halt = 1'b0;
      end else if (restart) begin
         n.cnt = first; n.rep = 1; n.halt = 1'b0;
      end else if (en && !s.halt) begin
         if (s.rep < s.cnt) begin
            n.rep = s.rep + 1;
         end else if (s.cnt == last) begin
            n.done = 1'b1;
            if (wrap) begin
               n.cnt = first; n.rep = 1;
            end else begin
               n.halt = 1'b1;
            end
         end else begin
            n.cnt = dir ? s.cnt - 1 : s.cnt + 1;
            n.rep = 1;
         end
      end
      return n;
   endfunction

   // One clock: advance the models with the presented inputs, then compare.
   task automatic cycle();
      @(posedge clk);
      m3 = model_step(m3, 3);
      m1 = model_step(m1, 1);
      #1;
      check_eq("m3_count", int'(count3), m3.cnt);
      check_eq("m3_rep", int'(rep3), m3.rep);
      check_eq("m3_done", int'(done3), int'(m3.done));
      check_eq("m3_halted", int'(halt3), int'(m3.halt));
      check_eq("m3_last_rep", int'(last3), int'((m3.rep == m3.cnt) && !m3.halt));
      check_eq("m1_count", int'(count1), m1.cnt);
      check_eq("m1_rep", int'(rep1), m1.rep);
      check_eq("m1_done", int'(done1), int'(m1.done));
      check_eq("m1_halted", int'(halt1), int'(m1.halt));
      check_eq("m1_last_rep", int'(last1), int'((m1.rep == m1.cnt) && !m1.halt));
   endtask

   initial begin
      int pos;
      m3 = '{cnt: 1, rep: 1, halt: 1'b0, done: 1'b0};
      m1 = m3;

      for (int v = 1; v <= 3; v++)
         for (int r = 1; r <= v; r++) begin up_cnt.push_back(v); up_rep.push_back(r); end
      for (int v = 3; v >= 1; v--)
         for (int r = 1; r <= v; r++) begin dn_cnt.push_back(v); dn_rep.push_back(r); end

      rst = 1'b1; en = 1'b0; restart = 1'b0; dir = 1'b0; wrap = 1'b1;
      cycle();

      // Ascending wrap after reset release; MAX_VAL=1 pulses every enabled cycle.
      check_eq("s1_reset_count", int'(count3), 1);
      rst = 1'b0; en = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         cycle();
         check_eq("s1_count", int'(count3), up_cnt[k % 6]);
         check_eq("s1_rep", int'(rep3), up_rep[k % 6]);
         check_eq("s1_done", int'(done3), int'((k % 6) == 0));
         check_eq("s1_m1_done", int'(done1), 1);
      end

      // Descending after restart.
      restart = 1'b1; dir = 1'b1;
      cycle();
      restart = 1'b0;
      for (int k = 0; k < 13; k++) begin
         if (k > 0) cycle();
         check_eq("s2_count", int'(count3), dn_cnt[k % 6]);
         check_eq("s2_rep", int'(rep3), dn_rep[k % 6]);
         check_eq("s2_last_rep", int'(last3), int'(dn_rep[k % 6] == dn_cnt[k % 6]));
      end

      // Halt mode: hold on 3, single done pulse, then restart.
      restart = 1'b1; dir = 1'b0; wrap = 1'b0;
      cycle();
      restart = 1'b0;
      for (int k = 1; k <= 26; k++) begin
         cycle();
         if (k == 10) wrap = 1'b1;
         check_eq("s3_count", int'(count3), (k < 6) ? up_cnt[k] : 3);
         check_eq("s3_halted", int'(halt3), int'(k >= 6));
         check_eq("s3_done", int'(done3), int'(k == 6));
      end
      restart = 1'b1;
      cycle();
      restart = 1'b0;
      check_eq("s3_restart_count", int'(count3), 1);
      check_eq("s3_restart_halted", int'(halt3), 0);

      // Enable toggling every other cycle.
      restart = 1'b1; wrap = 1'b1;
      cycle();
      restart = 1'b0;
      pos = 0;
      for (int i = 0; i < 24; i++) begin
         en = i[0];
         cycle();
         if (en) pos++;
         check_eq("s4_count", int'(count3), up_cnt[pos % 6]);
         check_eq("s4_rep", int'(rep3), up_rep[pos % 6]);
         check_eq("s4_done", int'(done3), int'(en && (pos % 6) == 0));
      end

      // Direction flips only take effect at a value boundary.
      en = 1'b1; restart = 1'b1; dir = 1'b0;
      cycle();
      restart = 1'b0;
      repeat (4) cycle();
      check_eq("s5_pre_count", int'(count3), 3);
      check_eq("s5_pre_rep", int'(rep3), 2);
      dir = 1'b1;
      cycle();
      check_eq("s5_mid_count", int'(count3), 3);
      check_eq("s5_mid_rep", int'(rep3), 3);
      cycle();
      check_eq("s5_rev_count", int'(count3), 2);
      check_eq("s5_rev_rep", int'(rep3), 1);
      dir = 1'b0;
      cycle();
      check_eq("s5_hold_count", int'(count3), 2);
      check_eq("s5_hold_rep", int'(rep3), 2);
      cycle();
      check_eq("s5_up_count", int'(count3), 3);

      // Reset mid-sequence, and in HALT together with restart.
      rst = 1'b1;
      cycle();
      check_eq("s6_mid_count", int'(count3), 1);
      check_eq("s6_mid_rep", int'(rep3), 1);
      rst = 1'b0; wrap = 1'b0; dir = 1'b0;
      repeat (8) cycle();
      check_eq("s6_in_halt", int'(halt3), 1);
      rst = 1'b1; restart = 1'b1; dir = 1'b1;
      cycle();
      check_eq("s6_rst_count", int'(count3), 1);
      check_eq("s6_rst_rep", int'(rep3), 1);
      check_eq("s6_rst_halted", int'(halt3), 0);
      check_eq("s6_rst_done", int'(done3), 0);
      // count=1 descending is terminal: wraps to MAX_VAL.
      rst = 1'b0; restart = 1'b0; wrap = 1'b1;
      cycle();
      check_eq("s6_term_count", int'(count3), 3);
      check_eq("s6_term_done", int'(done3), 1);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rst     = ($urandom_range(0, 49) == 0);
         restart = ($urandom_range(0, 19) == 0);
         en      = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 9) == 0) dir = ~dir;
         if ($urandom_range(0, 4) == 0) wrap = ~wrap;
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
